// File: rtl/mux4_1.sv
// Four-way bus steering mux: combinational output y plus a load-enabled
// registered copy (y_q) tagged with the select that produced it.
module mux4_1 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [WIDTH-1:0] I3,
   input  logic [1:0]       s,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic [1:0]       s_q,
   output logic             vld_q
);

   logic [WIDTH-1:0] mux_next;
   logic [WIDTH-1:0] y_reg;
   logic [1:0]       s_reg;
   logic             vld_reg;

   // An unknown select propagates as all-X so a bad select is visible in simulation.
   always_comb begin
      mux_next = '0;
      case (s)
         2'b00:   mux_next = I0;
         2'b01:   mux_next = I1;
         2'b10:   mux_next = I2;
         2'b11:   mux_next = I3;
         default: mux_next = 'x;
      endcase
   end

   assign y = mux_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_reg   <= '0;
         s_reg   <= 2'b00;
         vld_reg <= 1'b0;
      end else if (en) begin
         y_reg   <= mux_next;
         s_reg   <= s;
         vld_reg <= 1'b1;
      end
   end

   assign y_q   = y_reg;
   assign s_q   = s_reg;
   assign vld_q = vld_reg;

endmodule

// File: tb/tb_mux4_1.sv
// Scoreboard bench for mux4_1: stimulus pushes expected output snapshots,
// a monitor pops each one and compares it against the live DUT outputs.
module tb_mux4_1;

   typedef struct {
      string      name;
      logic [3:0] y;
      logic [3:0] y_q;
      logic [1:0] s_q;
      logic       vld_q;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] I0 = 4'b1010;
   logic [3:0] I1 = 4'b1010;
   logic [3:0] I2 = 4'b1010;
   logic [3:0] I3 = 4'b1010;
   logic [1:0] s = 2'b00;
   logic       en = 1'b0;
   logic [3:0] y;
   logic [3:0] y_q;
   logic [1:0] s_q;
   logic       vld_q;

   exp_t exp_q[$];
   int   push_cnt = 0;
   int   pop_cnt  = 0;
   int   n_vec    = 0;
   int   n_err    = 0;

   mux4_1 #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .I0    (I0),
      .I1    (I1),
      .I2    (I2),
      .I3    (I3),
      .s     (s),
      .en    (en),
      .y     (y),
      .y_q   (y_q),
      .s_q   (s_q),
      .vld_q (vld_q)
   );

   always #5 clk = ~clk;

   // Monitor: compares each queued expectation against the outputs 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         wait (push_cnt != pop_cnt);
         #1;
         e = exp_q.pop_front();
         pop_cnt++;
         n_vec++;
         if (y !== e.y || y_q !== e.y_q || s_q !== e.s_q || vld_q !== e.vld_q) begin
            n_err++;
            $display("FAIL %s: got y=%b y_q=%b s_q=%b vld_q=%b, expected y=%b y_q=%b s_q=%b vld_q=%b",
                     e.name, y, y_q, s_q, vld_q, e.y, e.y_q, e.s_q, e.vld_q);
         end else begin
            $display("vec %0d %s: y=%b y_q=%b s_q=%b vld_q=%b", n_vec, e.name, y, y_q, s_q, vld_q);
         end
      end
   end

   task automatic expect_out(input string name, input logic [3:0] ey, input logic [3:0] eyq,
                             input logic [1:0] esq, input logic evld);
      exp_t e;
      e.name = name; e.y = ey; e.y_q = eyq; e.s_q = esq; e.vld_q = evld;
      exp_q.push_back(e);
      push_cnt++;
      for (int k = 0; k < 50 && pop_cnt != push_cnt; k++) #1;
      if (pop_cnt != push_cnt) begin
         n_err++;
         n_vec++;
         $display("FAIL %s: monitor did not consume expectation, got pending=%0d, expected pending=0",
                  name, push_cnt - pop_cnt);
         pop_cnt = push_cnt;
         exp_q.delete();
      end
   endtask

   task automatic set_in(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
      s = sel; I0 = a; I1 = b; I2 = c; I3 = d;
   endtask

   initial begin
      // Asynchronous reset between edges, no clock edge involved.
      #2;
      rst_n = 1'b0;
      expect_out("async_reset", 4'b1010, 4'b0000, 2'b00, 1'b0);

      // Reset held across an enabled edge keeps registers cleared.
      en = 1'b1;
      set_in(2'b01, 4'b1010, 4'b0111, 4'b1010, 4'b1010);
      @(posedge clk); #1;
      expect_out("reset_held", 4'b0111, 4'b0000, 2'b00, 1'b0);

      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b1;
      set_in(2'b00, 4'b1010, 4'b1010, 4'b1010, 4'b1010);
      @(posedge clk); #1;
      expect_out("equal_inputs", 4'b1010, 4'b0000, 2'b00, 1'b0);

      @(negedge clk);
      set_in(2'b01, 4'b1010, 4'b1111, 4'b1010, 4'b1010);
      expect_out("sel1", 4'b1111, 4'b0000, 2'b00, 1'b0);
      set_in(2'b10, 4'b1010, 4'b1010, 4'b1100, 4'b1010);
      expect_out("sel2", 4'b1100, 4'b0000, 2'b00, 1'b0);
      set_in(2'b11, 4'b1000, 4'b0010, 4'b1110, 4'b1010);
      expect_out("sel3", 4'b1010, 4'b0000, 2'b00, 1'b0);

      // First enabled edge after reset release loads normally.
      @(negedge clk);
      en = 1'b1;
      set_in(2'b10, 4'b1010, 4'b1010, 4'b1100, 4'b1010);
      @(posedge clk); #1;
      expect_out("load_sel2", 4'b1100, 4'b1100, 2'b10, 1'b1);

      @(negedge clk);
      en = 1'b0;
      s = 2'b00;
      @(posedge clk); #1;
      expect_out("hold_en0", 4'b1010, 4'b1100, 2'b10, 1'b1);

      @(negedge clk);
      I0 = 4'b0001;
      @(posedge clk); #1;
      expect_out("hold_again", 4'b0001, 4'b1100, 2'b10, 1'b1);

      // Reset pulse between edges clears registers but leaves y alone.
      @(negedge clk);
      rst_n = 1'b0;
      expect_out("midop_reset", 4'b0001, 4'b0000, 2'b00, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      set_in(2'b11, 4'b0001, 4'b1010, 4'b1100, 4'b0110);
      @(posedge clk); #1;
      expect_out("reload_sel3", 4'b0110, 4'b0110, 2'b11, 1'b1);

      @(negedge clk);
      set_in(2'b01, 4'b0001, 4'b1001, 4'b1100, 4'b0110);
      @(posedge clk); #1;
      expect_out("load_sel1", 4'b1001, 4'b1001, 2'b01, 1'b1);

      // Reset asserted with a pending load wins on that edge.
      @(negedge clk);
      rst_n = 1'b0;
      set_in(2'b10, 4'b0001, 4'b1001, 4'b1011, 4'b0110);
      @(posedge clk); #1;
      expect_out("reset_beats_load", 4'b1011, 4'b0000, 2'b00, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      set_in(2'b00, 4'b0101, 4'b1001, 4'b1011, 4'b0110);
      @(posedge clk); #1;
      expect_out("load_sel0", 4'b0101, 4'b0101, 2'b00, 1'b1);

      // Select and data change together before the edge.
      @(negedge clk);
      set_in(2'b10, 4'b1111, 4'b1111, 4'b0011, 4'b1111);
      expect_out("simul_change", 4'b0011, 4'b0101, 2'b00, 1'b1);
      @(posedge clk); #1;
      expect_out("simul_capture", 4'b0011, 4'b0011, 2'b10, 1'b1);

      #10;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
